wb_bram_ctrl: RTL and testbench



---
 rtl/wb_bram_ctrl_if.sv | 23 ++
 rtl/wb_bram_ctrl.sv | 179 +++++++++++++++++
 tb/tb_wb_bram_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_ctrl_if.sv
// Wishbone classic bus bundle between the QSPI master port and the BRAM controller.
// Signal names keep the slave-side _i/_o orientation used at the controller.
interface wb_bram_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_we_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave fronting a single-port synchronous block RAM, with
// saturating write/read/error counters, a counter-clear register and error decode.
module wb_bram_ctrl #(
  parameter int AW    = 9,
  parameter int CNT_W = 16
) (
  input  logic          sys_clk,
  input  logic          rst,
  wb_bram_ctrl_if.slave wbs,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      dat_q, dat_d;
  logic             ack_q, err_q;
  logic             wr_q, wr_d;
  logic             clr_q, clr_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        req_s;
  logic        ram_hit_s;
  logic        reg_hit_s;
  logic        idle_s;
  logic [31:0] reg_rdata_s;

  assign req_s     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign ram_hit_s = (wbs.wbs_adr_i[31:AW+2] == {(30-AW){1'b0}});
  assign reg_hit_s = (wbs.wbs_adr_i[31:4] == 28'h0000100);
  assign idle_s    = (state_q == ST_IDLE);

  // The RAM port follows the bus only while idle; rst forces it quiet immediately.
  assign mem_en    = idle_s & req_s & ram_hit_s & ~rst;
  assign mem_we    = {4{mem_en & wbs.wbs_we_i}} & wbs.wbs_sel_i;
  assign mem_addr  = wbs.wbs_adr_i[AW+1:2];
  assign mem_wdata = wbs.wbs_dat_i;

  assign wbs.wbs_dat_o = dat_q;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_err_o = err_q;

  // Register-space read mux
  always_comb begin
    reg_rdata_s = 32'd0;
    case (wbs.wbs_adr_i[3:2])
      2'd0:    reg_rdata_s = zext_cnt(wr_cnt_q);
      2'd1:    reg_rdata_s = zext_cnt(rd_cnt_q);
      2'd2:    reg_rdata_s = zext_cnt(err_cnt_q);
      2'd3:    reg_rdata_s = 32'd0;
      default: reg_rdata_s = 32'd0;
    endcase
  end

  // Next-state, data capture and transaction-kind tracking
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    wr_d    = wr_q;
    clr_d   = clr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          wr_d  = wbs.wbs_we_i;
          clr_d = 1'b0;
          if (ram_hit_s) begin
            dat_d   = 32'd0;
            state_d = wbs.wbs_we_i ? ST_ACK : ST_RD;
          end else if (reg_hit_s) begin
            dat_d   = wbs.wbs_we_i ? 32'd0 : reg_rdata_s;
            clr_d   = wbs.wbs_we_i & (wbs.wbs_adr_i[3:2] == 2'd3);
            state_d = ST_ACK;
          end else begin
            dat_d   = 32'd0;
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (wbs.wbs_cyc_i) begin
          dat_d   = mem_rdata;
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        dat_d   = 32'd0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        dat_d   = 32'd0;
        state_d = ST_IDLE;
      end
      default: begin
        dat_d   = 32'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counters move during the ack/err cycle, so a register read sees pre-increment values
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == ST_ACK) begin
      if (clr_q) begin
        wr_cnt_d  = {CNT_W{1'b0}};
        rd_cnt_d  = {CNT_W{1'b0}};
        err_cnt_d = {CNT_W{1'b0}};
      end else if (wr_q) begin
        wr_cnt_d = sat_inc(wr_cnt_q);
      end else begin
        rd_cnt_d = sat_inc(rd_cnt_q);
      end
    end else if (state_q == ST_ERR) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dat_q     <= 32'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      clr_q     <= 1'b0;
      wr_cnt_q  <= {CNT_W{1'b0}};
      rd_cnt_q  <= {CNT_W{1'b0}};
      err_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      dat_q     <= dat_d;
      ack_q     <= (state_d == ST_ACK);
      err_q     <= (state_d == ST_ERR);
      wr_q      <= wr_d;
      clr_q     <= clr_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl: vector table plus hand sequences for
// counter saturation/clear, cycle abort and reset in the middle of a read.
module tb_wb_bram_ctrl;
  localparam int AW    = 9;
  localparam int CNT_W = 8;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        is_err;
    logic [31:0] exp_dat;
    int          exp_lat;
    logic        exp_en;
    logic [3:0]  exp_we;
  } vec_t;

  logic          sys_clk = 1'b0;
  logic          rst     = 1'b1;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [31:0]   ram [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  wb_bram_ctrl_if wb ();

  wb_bram_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .wbs      (wb),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  // Read-first synchronous RAM with byte write enables
  always @(posedge sys_clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input vec_t v, input string name);
    int   lat;
    logic got_ack;
    logic got_err;
    logic [31:0] got_dat;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = v.we;
    wb.wbs_adr_i = v.adr;
    wb.wbs_dat_i = v.dat;
    wb.wbs_sel_i = v.sel;
    #1;
    chk({name, "_mem_en"}, {31'd0, mem_en}, {31'd0, v.exp_en});
    chk({name, "_mem_we"}, {28'd0, mem_we}, {28'd0, v.exp_we});
    if (v.exp_en) chk({name, "_mem_addr"}, {23'd0, mem_addr}, {23'd0, v.adr[AW+1:2]});
    lat     = 0;
    got_ack = 1'b0;
    got_err = 1'b0;
    got_dat = 32'd0;
    while (lat < 8 && !(got_ack || got_err)) begin
      @(negedge sys_clk);
      lat++;
      if (wb.wbs_ack_o || wb.wbs_err_o) begin
        got_ack = wb.wbs_ack_o;
        got_err = wb.wbs_err_o;
        got_dat = wb.wbs_dat_o;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
      end
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    chk({name, "_resp"}, {30'd0, got_err, got_ack}, v.is_err ? 32'd2 : 32'd1);
    chk({name, "_lat"}, lat, v.exp_lat);
    chk({name, "_dat"}, got_dat, v.exp_dat);
    @(negedge sys_clk);
    chk({name, "_once"}, {30'd0, wb.wbs_err_o, wb.wbs_ack_o}, 32'd0);
  endtask

  task automatic rd_reg(input logic [31:0] adr, input logic [31:0] exp, input string name);
    txn('{1'b0, adr, 32'd0, 4'hF, 1'b0, exp, 1, 1'b0, 4'h0}, name);
  endtask

  vec_t vecs [18];

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000, 2'd1, 1'b1, 4'hF};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0, 32'hDEAD_BEEF, 2'd2, 1'b1, 4'h0};
    vecs[2]  = '{1'b0, 32'h0000_1004, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0001, 2'd1, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0001, 2'd1, 1'b0, 4'h0};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 1'b0, 32'h0000_0000, 2'd1, 1'b1, 4'h5};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0, 32'hDE22_BE44, 2'd2, 1'b1, 4'h0};
    vecs[6]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0000_0000, 2'd1, 1'b1, 4'h0};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1'b0, 32'hDE22_BE44, 2'd2, 1'b1, 4'h0};
    vecs[8]  = '{1'b0, 32'h0000_2000, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000, 2'd1, 1'b0, 4'h0};
    vecs[9]  = '{1'b1, 32'h0000_0800, 32'h0000_0001, 4'hF, 1'b1, 32'h0000_0000, 2'd1, 1'b0, 4'h0};
    vecs[10] = '{1'b0, 32'h0000_1008, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0002, 2'd1, 1'b0, 4'h0};
    vecs[11] = '{1'b0, 32'h0000_100C, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000, 2'd1, 1'b0, 4'h0};
    vecs[12] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0003, 2'd1, 1'b0, 4'h0};
    vecs[13] = '{1'b0, 32'h0000_1004, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0008, 2'd1, 1'b0, 4'h0};
    vecs[14] = '{1'b1, 32'h0000_1000, 32'h0000_0055, 4'hF, 1'b0, 32'h0000_0000, 2'd1, 1'b0, 4'h0};
    vecs[15] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0004, 2'd1, 1'b0, 4'h0};
    vecs[16] = '{1'b1, 32'h0000_07FC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0000_0000, 2'd1, 1'b1, 4'hF};
    vecs[17] = '{1'b0, 32'h0000_07FC, 32'h0000_0000, 4'hF, 1'b0, 32'hA5A5_A5A5, 2'd2, 1'b1, 4'h0};

    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = 32'd0;
    wb.wbs_dat_i = 32'd0;
    wb.wbs_sel_i = 4'h0;

    // Reset state, including RAM port held quiet while a request is presented
    repeat (2) @(negedge sys_clk);
    chk("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    chk("rst_err", {31'd0, wb.wbs_err_o}, 32'd0);
    chk("rst_dat", wb.wbs_dat_o, 32'd0);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_adr_i = 32'h10;
    wb.wbs_sel_i = 4'hF;
    #1;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 18; i++) txn(vecs[i], $sformatf("v%0d", i));

    // Saturation of WR_CNT (5 writes so far) and clear
    for (int i = 0; i < 260; i++)
      txn('{1'b1, 32'h20, 32'(i), 4'hF, 1'b0, 32'd0, 1, 1'b1, 4'hF}, "sat_wr");
    rd_reg(32'h1000, 32'h0000_00FF, "sat_wrcnt");
    rd_reg(32'h1008, 32'h0000_0002, "sat_errcnt");
    txn('{1'b1, 32'h100C, 32'h0, 4'h0, 1'b0, 32'd0, 1, 1'b0, 4'h0}, "clr_wr");
    rd_reg(32'h1000, 32'h0, "clr_wrcnt");
    rd_reg(32'h1004, 32'h1, "clr_rdcnt");
    rd_reg(32'h1008, 32'h0, "clr_errcnt");

    // Abort: cyc dropped while the read sits in RD
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = 32'h10;
    #1;
    chk("abort_mem_en", {31'd0, mem_en}, 32'd1);
    @(negedge sys_clk);
    chk("abort_rd_ack", {30'd0, wb.wbs_err_o, wb.wbs_ack_o}, 32'd0);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    repeat (2) begin
      @(negedge sys_clk);
      chk("abort_no_ack", {30'd0, wb.wbs_err_o, wb.wbs_ack_o}, 32'd0);
    end
    rd_reg(32'h1004, 32'h3, "abort_rdcnt");
    txn('{1'b0, 32'h10, 32'd0, 4'hF, 1'b0, 32'hDE22_BE44, 2, 1'b1, 4'h0}, "abort_next");

    // Reset asserted while in RD
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = 32'h10;
    @(negedge sys_clk);
    rst = 1'b1;
    #1;
    chk("rstrd_ack", {30'd0, wb.wbs_err_o, wb.wbs_ack_o}, 32'd0);
    chk("rstrd_dat", wb.wbs_dat_o, 32'd0);
    chk("rstrd_mem_en", {31'd0, mem_en}, 32'd0);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      chk("rstrd_no_ack", {30'd0, wb.wbs_err_o, wb.wbs_ack_o}, 32'd0);
    end
    rd_reg(32'h1004, 32'h0, "rstrd_rdcnt");
    rd_reg(32'h1000, 32'h0, "rstrd_wrcnt");
    rd_reg(32'h1008, 32'h0, "rstrd_errcnt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
